// File: rtl/approx_add14_err_monitor.sv
// rtl/approx_add14_err_monitor.sv - windowed error-distance statistics for the 14-bit approximate adder
// Optional feature macro: APPROX_MON_BIAS_EN (signed bias accumulator; bias port tied to 0 when undefined)
module approx_add14_err_monitor #(
    parameter int WIN_LOG2 = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [13:0]             a,
    input  logic [13:0]             b,
    input  logic [14:0]             approx_sum,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [15+WIN_LOG2-1:0]  ed_sum,
    output logic [14:0]             ed_mean,
    output logic [14:0]             ed_max,
    output logic [WIN_LOG2:0]       err_cnt,
    output logic [16+WIN_LOG2-1:0]  bias
);

    typedef enum logic {ACCUM, REPORT} state_t;

    // Counter value meaning "whole window accepted" (2^WIN_LOG2)
    localparam logic [WIN_LOG2:0] WIN_FULL = {1'b1, {WIN_LOG2{1'b0}}};

    state_t              state;
    state_t              state_next;
    logic [WIN_LOG2:0]   accepted;
    logic                accept;
    logic                absorb_last;
    logic                handshake;

    logic [14:0]         exact;
    logic [15:0]         diff;
    logic [15:0]         diff_abs;
    logic [14:0]         ed;

    logic                s1_valid;
    logic [14:0]         s1_ed;

    // Exact reference sum and signed/absolute error of the approximate result
    always_comb begin
        exact    = {1'b0, a} + {1'b0, b};
        diff     = {1'b0, approx_sum} - {1'b0, exact};
        diff_abs = diff[15] ? (16'd0 - diff) : diff;
        ed       = diff_abs[14:0];
    end

    assign in_ready    = (state == ACCUM) && (accepted < WIN_FULL);
    assign out_valid   = (state == REPORT);
    assign accept      = in_valid && in_ready;
    assign handshake   = (state == REPORT) && out_ready;
    // The last sample reaches S2 while the counter already reads a full window
    assign absorb_last = (state == ACCUM) && s1_valid && (accepted == WIN_FULL);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; clear overrides both the report hold and the handshake
    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = ACCUM;
        end else begin
            case (state)
                ACCUM:   if (absorb_last) state_next = REPORT;
                REPORT:  if (handshake)   state_next = ACCUM;
                default: state_next = ACCUM;
            endcase
        end
    end

    // Accepted-sample counter for the current window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            accepted <= '0;
        end else if (clear || handshake) begin
            accepted <= '0;
        end else if (accept) begin
            accepted <= accepted + (WIN_LOG2+1)'(1);
        end
    end

    // Stage 1: capture the error distance of each accepted sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_ed    <= '0;
        end else begin
            s1_valid <= accept && !clear;
            if (accept) begin
                s1_ed <= ed;
            end
        end
    end

    // Stage 2: fold the registered error into the window accumulators
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ed_sum  <= '0;
            ed_max  <= '0;
            err_cnt <= '0;
        end else if (clear || handshake) begin
            ed_sum  <= '0;
            ed_max  <= '0;
            err_cnt <= '0;
        end else if (s1_valid && (state == ACCUM)) begin
            ed_sum  <= ed_sum + {{WIN_LOG2{1'b0}}, s1_ed};
            if (s1_ed > ed_max) begin
                ed_max <= s1_ed;
            end
            err_cnt <= err_cnt + {{WIN_LOG2{1'b0}}, (s1_ed != 15'd0)};
        end
    end

    // Truncating mean over the window: drop the WIN_LOG2 fraction bits
    assign ed_mean = ed_sum[WIN_LOG2 +: 15];

`ifdef APPROX_MON_BIAS_EN
    logic [15:0] s1_diff;

    // Stage 1 signed error, kept only when bias tracking is built
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_diff <= '0;
        end else if (accept) begin
            s1_diff <= diff;
        end
    end

    // Stage 2 signed bias accumulator (sign-extended difference)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bias <= '0;
        end else if (clear || handshake) begin
            bias <= '0;
        end else if (s1_valid && (state == ACCUM)) begin
            bias <= bias + {{WIN_LOG2{s1_diff[15]}}, s1_diff};
        end
    end
`else
    assign bias = '0;
`endif

endmodule

// File: tb/tb_approx_add14_err_monitor.sv
// tb/tb_approx_add14_err_monitor.sv - randomized and directed bench for approx_add14_err_monitor
module tb_approx_add14_err_monitor;

    localparam int W = 2;
    localparam int N = 1 << W;
`ifdef APPROX_MON_BIAS_EN
    localparam bit BIAS_ON = 1'b1;
`else
    localparam bit BIAS_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic [13:0]       a;
    logic [13:0]       b;
    logic [14:0]       approx_sum;
    logic              out_valid;
    logic              out_ready;
    logic [15+W-1:0]   ed_sum;
    logic [14:0]       ed_mean;
    logic [14:0]       ed_max;
    logic [W:0]        err_cnt;
    logic [16+W-1:0]   bias;

    int tests = 0;
    int fails = 0;

    // Reference model: list of samples accepted in the current window
    int q_ed[$];
    int q_diff[$];
    bit m_report = 1'b0;
    bit m_filled = 1'b0;
    bit exp_ready = 1'b1;

    approx_add14_err_monitor #(.WIN_LOG2(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .approx_sum (approx_sum),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ed_sum     (ed_sum),
        .ed_mean    (ed_mean),
        .ed_max     (ed_max),
        .err_cnt    (err_cnt),
        .bias       (bias)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint m_sum();
        longint s = 0;
        foreach (q_ed[i]) s += q_ed[i];
        return s;
    endfunction

    function automatic longint m_max();
        longint m = 0;
        foreach (q_ed[i]) if (q_ed[i] > m) m = q_ed[i];
        return m;
    endfunction

    function automatic longint m_cnt();
        longint c = 0;
        foreach (q_ed[i]) if (q_ed[i] != 0) c++;
        return c;
    endfunction

    function automatic longint m_bias();
        longint s = 0;
        foreach (q_diff[i]) s += q_diff[i];
        return BIAS_ON ? s : 0;
    endfunction

    // Compare process: advance the model one edge, then check the DUT
    initial begin : compare
        bit sv, sc, sor, sr;
        int sa, sb, ss, d;
        forever begin
            @(posedge clk);
            sv = in_valid; sc = clear; sor = out_ready; sr = rst_n;
            sa = int'(a); sb = int'(b); ss = int'(approx_sum);
            #1;
            if (!sr || sc) begin
                q_ed.delete(); q_diff.delete();
                m_report = 1'b0; m_filled = 1'b0;
            end else if (m_report) begin
                if (sor) begin
                    q_ed.delete(); q_diff.delete();
                    m_report = 1'b0;
                end
            end else begin
                if (m_filled) begin
                    m_report = 1'b1;
                    m_filled = 1'b0;
                end
                if (sv && exp_ready) begin
                    d = ss - (sa + sb);
                    q_diff.push_back(d);
                    q_ed.push_back(d < 0 ? -d : d);
                    if (q_ed.size() == N) m_filled = 1'b1;
                end
            end
            exp_ready = !m_report && (q_ed.size() < N);
            chk("in_ready", longint'(in_ready), longint'(exp_ready));
            chk("out_valid", longint'(out_valid), longint'(m_report));
            if (!sr) begin
                chk("rst_ed_sum", longint'(ed_sum), 0);
                chk("rst_ed_max", longint'(ed_max), 0);
                chk("rst_err_cnt", longint'(err_cnt), 0);
                chk("rst_bias", longint'($signed(bias)), 0);
            end else if (m_report) begin
                chk("ed_sum", longint'(ed_sum), m_sum());
                chk("ed_mean", longint'(ed_mean), m_sum() >> W);
                chk("ed_max", longint'(ed_max), m_max());
                chk("err_cnt", longint'(err_cnt), m_cnt());
                chk("bias", longint'($signed(bias)), m_bias());
            end
        end
    end

    task automatic send(input int av, input int bv, input int sv);
        int n = 0;
        a = 14'(av); b = 14'(bv); approx_sum = 15'(sv);
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            tests++; fails++;
            $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_report();
        int n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            tests++; fails++;
            $display("FAIL report_timeout: out_valid %b, required 1", out_valid);
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic chk_result(input string tag, input longint s, input longint mx,
                              input longint c, input longint bs);
        chk({tag, "_sum"}, longint'(ed_sum), s);
        chk({tag, "_mean"}, longint'(ed_mean), s >> W);
        chk({tag, "_max"}, longint'(ed_max), mx);
        chk({tag, "_cnt"}, longint'(err_cnt), c);
        chk({tag, "_bias"}, longint'($signed(bias)), BIAS_ON ? bs : 0);
    endtask

    initial begin : stimulus
        int ex, ap;
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; approx_sum = '0;
        @(negedge clk);
        chk("reset_in_ready", longint'(in_ready), 1);
        chk("reset_out_valid", longint'(out_valid), 0);
        chk("reset_ed_sum", longint'(ed_sum), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Constant ED 511 window; report appears one edge after the last accept
        for (int i = 0; i < N; i++) send(0, 0, 511);
        chk("w1_valid_early", longint'(out_valid), 0);
        chk("w1_ready_full", longint'(in_ready), 0);
        @(negedge clk);
        chk("w1_valid_late", longint'(out_valid), 1);
        chk_result("w1", 2044, 511, 4, 2044);
        chk("model_pin_sum", m_sum(), 2044);
        chk("model_pin_max", m_max(), 511);
        repeat (5) @(negedge clk);
        chk("w1_hold_ready", longint'(in_ready), 0);
        chk_result("w1_hold", 2044, 511, 4, 2044);
        handshake();
        chk("w1_after_hs_ready", longint'(in_ready), 1);
        chk("w1_after_hs_valid", longint'(out_valid), 0);

        // Operands at maximum: each approximate sum overshoots by one
        for (int i = 0; i < N; i++) send(16383, 16383, 32767);
        wait_report();
        chk_result("w2", 4, 1, 4, 4);
        handshake();

        // Mostly exact samples with one error of 7, then an immediate window
        send(1, 2, 3); send(1, 2, 3); send(1, 2, 10); send(5, 5, 10);
        wait_report();
        chk_result("w3", 7, 7, 1, 7);
        chk("model_pin_cnt", m_cnt(), 1);
        handshake();
        for (int i = 0; i < N; i++) send(10, 10, 13);
        wait_report();
        chk_result("w4", 28, 7, 4, -28);
        chk("model_pin_bias", m_bias(), BIAS_ON ? -28 : 0);

        // Clear coinciding with the report handshake
        handshake();
        for (int i = 0; i < N; i++) send(0, 0, 100);
        wait_report();
        clear = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        clear = 1'b0; out_ready = 1'b0;
        chk("clr_rep_valid", longint'(out_valid), 0);
        for (int i = 0; i < N; i++) send(1, 1, 3);
        wait_report();
        chk_result("w5", 4, 1, 4, 4);
        handshake();

        // Clear after a single accept discards that sample
        send(0, 0, 1000);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        for (int i = 0; i < N; i++) send(2, 2, 4);
        wait_report();
        chk_result("w6", 0, 0, 0, 0);
        handshake();

        // Asynchronous reset in the middle of a window
        send(0, 0, 300); send(0, 0, 300);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_ed_sum", longint'(ed_sum), 0);
        chk("arst_ed_max", longint'(ed_max), 0);
        chk("arst_err_cnt", longint'(err_cnt), 0);
        chk("arst_out_valid", longint'(out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("arst_in_ready", longint'(in_ready), 1);
        for (int i = 0; i < N; i++) send(100, 0, 90);
        wait_report();
        chk_result("w7", 10 * N, 10, N, -10 * N);
        handshake();

        // Randomized traffic with random backpressure and occasional clears
        for (int cyc = 0; cyc < 800; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 1) == 1);
            clear     = ($urandom_range(0, 49) == 0);
            a = 14'($urandom_range(0, 16383));
            b = 14'($urandom_range(0, 16383));
            ex = int'(a) + int'(b);
            case ($urandom_range(0, 3))
                0: ap = ex;
                1: ap = $urandom_range(0, 32767);
                default: ap = ex + $urandom_range(0, 40) - 20;
            endcase
            if (ap < 0) ap = 0;
            if (ap > 32767) ap = 32767;
            approx_sum = 15'(ap);
            @(negedge clk);
        end
        in_valid = 1'b0; clear = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
